alu_arbiter: RTL and testbench

- Shares the single combinational ALU between NUM_REQ requesters, such as the integer execute path and the address-generation path.
- Each requester issues operations over a valid/ready request channel and gets results back over a valid/ready response channel.
- The block selects requesters round-robin, drives registered operands and func into the ALU, captures the result, and routes it back to the requester that issued the operation.
- Only one operation is in flight at a time.

---
 rtl/alu_arbiter.sv | 141 ++++++++++++++
 tb/tb_alu_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ requesters.
// One operation in flight at a time: grant, execute for one cycle, then hold the response until accepted.
//
// state  | meaning
// S_IDLE | offer req_ready to the next valid requester after last_grant
// S_EXEC | registered operands at the ALU, capture its result
// S_RESP | response held on resp_valid[grant_id] until resp_ready[grant_id]
module alu_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [3*NUM_REQ-1:0]           req_func,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_operand_1,
    input  logic [DATA_WIDTH*NUM_REQ-1:0]  req_operand_2,
    output logic [NUM_REQ-1:0]             resp_valid,
    input  logic [NUM_REQ-1:0]             resp_ready,
    output logic [DATA_WIDTH-1:0]          resp_result,
    output logic                           resp_err,
    output logic [2:0]                     alu_func,
    output logic [DATA_WIDTH-1:0]          alu_operand_1,
    output logic [DATA_WIDTH-1:0]          alu_operand_2,
    input  logic [DATA_WIDTH-1:0]          alu_result
);

    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [GW-1:0] LAST_RST = GW'(NUM_REQ - 1);
    localparam logic [2:0]    FUNC_ERR = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [GW-1:0]         last_grant_q, last_grant_d;
    logic [GW-1:0]         grant_id_q, grant_id_d;
    logic [2:0]            func_q, func_d;
    logic [DATA_WIDTH-1:0] op1_q, op1_d;
    logic [DATA_WIDTH-1:0] op2_q, op2_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  err_q, err_d;

    logic                  pick_vld;
    logic [GW-1:0]         pick_id;

    // First valid requester strictly after last_grant, wrapping around.
    always_comb begin
        int idx;
        idx      = 0;
        pick_vld = 1'b0;
        pick_id  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant_q) + k) % NUM_REQ;
            if (!pick_vld && req_valid[idx]) begin
                pick_vld = 1'b1;
                pick_id  = idx[GW-1:0];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        func_d       = func_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        result_d     = result_q;
        err_d        = err_q;
        req_ready    = '0;
        resp_valid   = '0;

        case (state_q)
            S_IDLE: begin
                if (pick_vld && !reset) begin
                    req_ready[pick_id] = 1'b1;
                    func_d     = req_func[3*int'(pick_id) +: 3];
                    op1_d      = req_operand_1[DATA_WIDTH*int'(pick_id) +: DATA_WIDTH];
                    op2_d      = req_operand_2[DATA_WIDTH*int'(pick_id) +: DATA_WIDTH];
                    grant_id_d = pick_id;
                    state_d    = S_EXEC;
                end
            end
            S_EXEC: begin
                if (func_q == FUNC_ERR) begin
                    result_d = '0;
                    err_d    = 1'b1;
                end else begin
                    result_d = alu_result;
                    err_d    = 1'b0;
                end
                state_d = S_RESP;
            end
            S_RESP: begin
                resp_valid[grant_id_q] = 1'b1;
                if (resp_ready[grant_id_q]) begin
                    last_grant_d = grant_id_q;
                    err_d        = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= LAST_RST;
            grant_id_q   <= '0;
            func_q       <= 3'b000;
            op1_q        <= '0;
            op2_q        <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            func_q       <= func_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    assign alu_func      = func_q;
    assign alu_operand_1 = op1_q;
    assign alu_operand_2 = op2_q;
    assign resp_result   = result_q;
    assign resp_err      = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: transaction-level model checked every cycle, plus directed literal checks.
module tb_alu_arbiter;
    localparam int N  = 2;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_ready, resp_valid, resp_ready, rr_en;
    logic [3*N-1:0]  req_func;
    logic [DW*N-1:0] req_operand_1, req_operand_2;
    logic [DW-1:0]   resp_result, alu_operand_1, alu_operand_2, alu_result;
    logic            resp_err;
    logic [2:0]      alu_func;

    always #5 clk = ~clk;

    alu_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_func(req_func),
        .req_operand_1(req_operand_1), .req_operand_2(req_operand_2),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_err(resp_err),
        .alu_func(alu_func), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
        .alu_result(alu_result)
    );

    // Reference ALU: 111 yields junk that the arbiter must suppress.
    function automatic logic [31:0] alu_fn(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] s;
        s = a;
        case (f)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a << b[4:0];
            3'b101:  return a >> b[4:0];
            3'b110:  return s >>> b[4:0];
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_func, alu_operand_1, alu_operand_2);
    assign resp_ready = rr_en;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct packed {logic [2:0] f; logic [31:0] a; logic [31:0] b;} op_t;
    typedef struct packed {logic [1:0] id; logic [31:0] res; logic err;} rsp_t;

    op_t      opq[N][$];
    rsp_t     resp_log[$];
    int       grant_log[$];
    logic [N-1:0] hs_q = '0;

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N] === 1'b1) return (last + k) % N;
        end
        return -1;
    endfunction

    // Requester drivers: present queue heads, pop on accepted handshake.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < N; i++) begin
            if (hs_q[i] && opq[i].size() > 0) void'(opq[i].pop_front());
            if (opq[i].size() > 0) begin
                req_valid[i]              = 1'b1;
                req_func[3*i +: 3]        = opq[i][0].f;
                req_operand_1[DW*i +: DW] = opq[i][0].a;
                req_operand_2[DW*i +: DW] = opq[i][0].b;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    end

    // Transaction model: busy with an operation for `m_age` cycles since acceptance.
    bit          m_busy;
    int          m_age, m_owner, m_last;
    logic [2:0]  m_func;
    logic [31:0] m_a, m_b, m_res;
    logic        m_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 0; m_age = 0; m_owner = 0; m_last = N - 1;
            m_func = 3'b000; m_a = '0; m_b = '0; m_res = '0; m_err = 1'b0;
        end else if (!m_busy) begin
            int w;
            w = pick(req_valid, m_last);
            if (w >= 0) begin
                m_busy  = 1; m_age = 0; m_owner = w;
                m_func  = req_func[3*w +: 3];
                m_a     = req_operand_1[DW*w +: DW];
                m_b     = req_operand_2[DW*w +: DW];
            end
        end else begin
            if (m_age == 0) begin
                m_res = (m_func == 3'b111) ? 32'h0 : alu_fn(m_func, m_a, m_b);
                m_err = (m_func == 3'b111);
            end else if (resp_ready[m_owner]) begin
                m_busy = 0; m_last = m_owner; m_err = 1'b0;
            end
            m_age++;
        end
    end

    // Per-cycle compare against the model, plus handshake logging.
    always @(negedge clk) begin
        logic [N-1:0] exp_rr, exp_rv, rh;
        int w;
        exp_rr = '0;
        exp_rv = '0;
        if (!reset && !m_busy) begin
            w = pick(req_valid, m_last);
            if (w >= 0) exp_rr[w] = 1'b1;
        end
        if (m_busy && m_age >= 1) exp_rv[m_owner] = 1'b1;
        chk("req_ready", 32'(req_ready), 32'(exp_rr));
        chk("resp_valid", 32'(resp_valid), 32'(exp_rv));
        chk("resp_result", resp_result, m_res);
        chk("resp_err", 32'(resp_err), 32'(m_err));
        chk("alu_func", 32'(alu_func), 32'(m_func));
        chk("alu_operand_1", alu_operand_1, m_a);
        chk("alu_operand_2", alu_operand_2, m_b);

        hs_q = req_valid & req_ready;
        rh   = resp_valid & resp_ready;
        for (int i = 0; i < N; i++) begin
            if (hs_q[i] === 1'b1) grant_log.push_back(i);
            if (rh[i] === 1'b1) resp_log.push_back({2'(i), resp_result, resp_err});
        end
    end

    task automatic push(input int id, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        opq[id].push_back({f, a, b});
    endtask

    task automatic wait_resp(input int target, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clk);
            if (resp_log.size() >= target) break;
        end
        if (k == budget) chk("resp_timeout", 32'(resp_log.size()), 32'(target));
        #2;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n, g, k;
        reset = 1'b0;
        rr_en = '1;
        req_valid = '0;
        req_func = '0;
        req_operand_1 = '0;
        req_operand_2 = '0;
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Single ADD from requester 0
        push(0, 3'b000, 32'd5, 32'd7);
        for (k = 0; k < 10; k++) begin
            @(negedge clk);
            if (req_ready !== '0) break;
        end
        chk("t1_req_ready", 32'(req_ready), 32'h1);
        @(negedge clk);
        chk("t1_exec_resp_valid", 32'(resp_valid), 32'h0);
        @(negedge clk);
        chk("t1_resp_valid", 32'(resp_valid), 32'h1);
        chk("t1_resp_result", resp_result, 32'd12);
        chk("t1_resp_err", 32'(resp_err), 32'h0);
        @(negedge clk);
        chk("t1_resp_valid_drop", 32'(resp_valid), 32'h0);
        @(posedge clk);
        #2;

        // Arithmetic and logical right shifts on requester 1
        n = resp_log.size();
        push(1, 3'b110, 32'h8000_0000, 32'd4);
        push(1, 3'b101, 32'h8000_0000, 32'd4);
        wait_resp(n + 2, 40);
        chk("t3_sra_id", 32'(resp_log[n].id), 32'd1);
        chk("t3_sra", resp_log[n].res, 32'hF800_0000);
        chk("t3_srl", resp_log[n+1].res, 32'h0800_0000);

        // Both requesters continuously valid: grants alternate
        n = resp_log.size();
        g = grant_log.size();
        push(0, 3'b001, 32'd10, 32'd3);
        push(0, 3'b001, 32'd10, 32'd3);
        push(1, 3'b100, 32'd1, 32'd4);
        push(1, 3'b100, 32'd1, 32'd4);
        wait_resp(n + 4, 100);
        for (int i = 0; i < 4; i++) begin
            chk("t2_grant_order", 32'(grant_log[g+i]), 32'(i % 2));
            chk("t2_resp_id", 32'(resp_log[n+i].id), 32'(i % 2));
            chk("t2_result", resp_log[n+i].res, (i % 2 == 0) ? 32'd7 : 32'd16);
        end

        // Illegal func then a legal one
        n = resp_log.size();
        push(0, 3'b111, 32'd3, 32'd4);
        push(0, 3'b000, 32'd1, 32'd1);
        wait_resp(n + 2, 40);
        chk("t4_err_result", resp_log[n].res, 32'h0);
        chk("t4_err_flag", 32'(resp_log[n].err), 32'h1);
        chk("t4_next_result", resp_log[n+1].res, 32'd2);
        chk("t4_next_err", 32'(resp_log[n+1].err), 32'h0);

        // Back-pressure on the response while requester 0 stays valid
        rr_en[0] = 1'b0;
        n = resp_log.size();
        g = grant_log.size();
        push(0, 3'b010, 32'hF0, 32'h3C);
        push(0, 3'b011, 32'hF0, 32'h0F);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (resp_valid[0] === 1'b1) break;
        end
        repeat (5) begin
            @(negedge clk);
            chk("t5_hold_resp_valid", 32'(resp_valid), 32'h1);
            chk("t5_hold_result", resp_result, 32'h30);
            chk("t5_hold_req_ready", 32'(req_ready), 32'h0);
        end
        @(posedge clk);
        #2;
        chk("t5_no_new_grant", 32'(grant_log.size()), 32'(g + 1));
        rr_en[0] = 1'b1;
        wait_resp(n + 2, 40);
        chk("t5_and", resp_log[n].res, 32'h30);
        chk("t5_or", resp_log[n+1].res, 32'hFF);

        // Reset while requester 1's operation is executing
        n = resp_log.size();
        push(0, 3'b000, 32'd2, 32'd2);
        wait_resp(n + 1, 40);
        n = resp_log.size();
        push(1, 3'b000, 32'd100, 32'd1);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if ((req_valid[1] & req_ready[1]) === 1'b1) break;
        end
        @(posedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("t6_rst_resp_result", resp_result, 32'h0);
        chk("t6_rst_alu_func", 32'(alu_func), 32'h0);
        chk("t6_rst_alu_op1", alu_operand_1, 32'h0);
        chk("t6_rst_req_ready", 32'(req_ready), 32'h0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        g = grant_log.size();
        push(0, 3'b000, 32'd3, 32'd4);
        push(1, 3'b000, 32'd9, 32'd9);
        wait_resp(n + 2, 60);
        chk("t6_first_grant", 32'(grant_log[g]), 32'h0);
        chk("t6_resp0_id", 32'(resp_log[n].id), 32'h0);
        chk("t6_resp0", resp_log[n].res, 32'd7);
        chk("t6_resp1_id", 32'(resp_log[n+1].id), 32'h1);
        chk("t6_resp1", resp_log[n+1].res, 32'd18);
        repeat (4) @(posedge clk);
        #2;
        chk("t6_resp_count", 32'(resp_log.size()), 32'(n + 2));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
